trace_stream_receiver: RTL and testbench

//  AXI-Stream slave that sinks the CMS trace packet stream and decodes each beat into fields:

---
 rtl/continuous_monitoring_system_pkg.sv | 43 ++++
 rtl/axis_skid_buffer.sv | 78 +++++++
 rtl/trace_stream_receiver.sv | 160 ++++++++++++++++
 tb/tb_trace_stream_receiver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/continuous_monitoring_system_pkg.sv
// Purpose: trace packet layout, field locations and receiver state shared by CMS transmitter and receiver.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package continuous_monitoring_system_pkg;

  localparam int RISC_V_INSTRUCTION_WIDTH            = 32;
  localparam int XLEN                                = 32;
  localparam int CLK_COUNTER_WIDTH                   = 16;
  localparam int NO_OF_PERFORMANCE_EVENTS            = 4;
  localparam int PERFORMANCE_EVENT_MOD_COUNTER_WIDTH = 8;
  localparam logic [RISC_V_INSTRUCTION_WIDTH-1:0] WFI_INSTRUCTION = 32'h1050_0073;

  // instr sits at the MSB end of the beat, counters at the LSB end
  typedef struct packed {
    logic [RISC_V_INSTRUCTION_WIDTH-1:0]                                    instr;
    logic [CLK_COUNTER_WIDTH-1:0]                                           clk_delta;
    logic [XLEN-1:0]                                                        pc;
    logic [NO_OF_PERFORMANCE_EVENTS-1:0]                                    overflow_map;
    logic [NO_OF_PERFORMANCE_EVENTS*PERFORMANCE_EVENT_MOD_COUNTER_WIDTH-1:0] counters;
  } trace_pkt_t;

  localparam int AXI_DATA_WIDTH             = $bits(trace_pkt_t);
  localparam int OVERFLOW_MAP_LOCATION      = NO_OF_PERFORMANCE_EVENTS * PERFORMANCE_EVENT_MOD_COUNTER_WIDTH;
  localparam int PC_LOCATION                = OVERFLOW_MAP_LOCATION + NO_OF_PERFORMANCE_EVENTS;
  localparam int CLK_COUNTER_DELTA_LOCATION = PC_LOCATION + XLEN;
  localparam int INSTR_LOCATION             = CLK_COUNTER_DELTA_LOCATION + CLK_COUNTER_WIDTH;

  typedef enum logic [1:0] {
    TRX_IDLE,
    TRX_STREAMING,
    TRX_ENDED
  } trace_rx_state_t;

  // counter[0] occupies the most significant slot of the counter region
  function automatic logic [PERFORMANCE_EVENT_MOD_COUNTER_WIDTH-1:0] event_counter(
    input trace_pkt_t pkt,
    input int         idx
  );
    return pkt.counters[(NO_OF_PERFORMANCE_EVENTS-1-idx)*PERFORMANCE_EVENT_MOD_COUNTER_WIDTH
                        +: PERFORMANCE_EVENT_MOD_COUNTER_WIDTH];
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Purpose: 2-entry skid FIFO between an AXI-Stream slave port and a valid/ready consumer.
// Latency: beat accepted at cycle N is visible on m_dat at N+1; 1 beat/clk sustained.
// Backpressure: s_rdy is a registered ~full; clear flushes both entries and drops s_rdy for a cycle.
module axis_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  s_vld,
  output logic                  s_rdy,
  input  logic [DATA_WIDTH-1:0] s_dat,
  output logic                  m_vld,
  input  logic                  m_rdy,
  output logic [DATA_WIDTH-1:0] m_dat
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  push, pop;

  assign push  = s_vld & s_rdy;
  assign pop   = m_vld & m_rdy;
  assign m_vld = (cnt_q != 2'd0);
  assign m_dat = head_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          head_d = s_dat;
          cnt_d  = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = s_dat;
        end else if (push) begin
          tail_d = s_dat;
          cnt_d  = 2'd2;
        end else if (pop) begin
          cnt_d  = 2'd0;
        end
      end
      default: begin
        // s_rdy is low when full, so only a pop can happen here
        if (pop) begin
          head_d = tail_q;
          cnt_d  = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      s_rdy  <= 1'b0;
    end else if (clear) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
      s_rdy  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      tail_q <= tail_d;
      s_rdy  <= (cnt_d != 2'd2);
    end
  end

endmodule

// File: rtl/trace_stream_receiver.sv
// Purpose: sink the CMS trace stream, decode fields, rebuild timestamps, count packets/frames, detect end of trace.
// Latency: beat accepted at N is decoded on out_* at N+1; outputs hold while out_valid & ~out_ready.
// Backpressure: out_ready low fills the 2-entry skid, then S_AXIS_tready drops. Option: TRACE_RX_EVENT_TOTALS_EN.
module trace_stream_receiver
  import continuous_monitoring_system_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = 64,
  parameter int TOTAL_WIDTH     = 48
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                S_AXIS_tvalid,
  output logic                                S_AXIS_tready,
  input  logic [AXI_DATA_WIDTH-1:0]           S_AXIS_tdata,
  input  logic                                S_AXIS_tlast,
  input  logic                                clear,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [RISC_V_INSTRUCTION_WIDTH-1:0] out_instr,
  output logic [XLEN-1:0]                     out_pc,
  output logic [CLK_COUNTER_WIDTH-1:0]        out_clk_delta,
  output logic [TIMESTAMP_WIDTH-1:0]          out_timestamp,
  output logic [NO_OF_PERFORMANCE_EVENTS-1:0] out_overflow_map,
  output logic [NO_OF_PERFORMANCE_EVENTS*PERFORMANCE_EVENT_MOD_COUNTER_WIDTH-1:0] out_counters,
  output logic                                out_last,
  output logic [31:0]                         pkt_count,
  output logic [31:0]                         frame_count,
  output logic                                end_of_trace,
  output logic                                err_zero_delta
`ifdef TRACE_RX_EVENT_TOTALS_EN
  ,
  input  logic [$clog2(NO_OF_PERFORMANCE_EVENTS)-1:0] total_sel,
  output logic [TOTAL_WIDTH-1:0]                      total_value
`endif
);

  localparam int CW = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH;

  logic [AXI_DATA_WIDTH:0]      buf_dat;
  trace_pkt_t                   head;
  logic                         hs;
  logic                         is_wfi_last;
  logic [TIMESTAMP_WIDTH-1:0]   ts_acc;
  logic [TIMESTAMP_WIDTH-1:0]   ts_base;
  logic [TIMESTAMP_WIDTH-1:0]   delta_ext;
  trace_rx_state_t              state_q, state_d;

  axis_skid_buffer #(
    .DATA_WIDTH(AXI_DATA_WIDTH + 1)
  ) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .s_vld (S_AXIS_tvalid),
    .s_rdy (S_AXIS_tready),
    .s_dat ({S_AXIS_tlast, S_AXIS_tdata}),
    .m_vld (out_valid),
    .m_rdy (out_ready),
    .m_dat (buf_dat)
  );

  assign head             = trace_pkt_t'(buf_dat[AXI_DATA_WIDTH-1:0]);
  assign out_last         = buf_dat[AXI_DATA_WIDTH];
  assign out_instr        = buf_dat[INSTR_LOCATION +: RISC_V_INSTRUCTION_WIDTH];
  assign out_clk_delta    = buf_dat[CLK_COUNTER_DELTA_LOCATION +: CLK_COUNTER_WIDTH];
  assign out_pc           = buf_dat[PC_LOCATION +: XLEN];
  assign out_overflow_map = head.overflow_map;
  assign hs               = out_valid & out_ready;
  assign is_wfi_last      = out_last & (out_instr == WFI_INSTRUCTION);
  assign end_of_trace     = (state_q == TRX_ENDED);

  always_comb begin
    out_counters = '0;
    for (int i = 0; i < NO_OF_PERFORMANCE_EVENTS; i++) begin
      out_counters[i*CW +: CW] = event_counter(head, i);
    end
  end

  // A packet leaving ENDED starts a fresh time base
  always_comb begin
    delta_ext                        = '0;
    delta_ext[CLK_COUNTER_WIDTH-1:0] = out_clk_delta;
    ts_base                          = (state_q == TRX_ENDED) ? '0 : ts_acc;
    out_timestamp                    = ts_base + delta_ext;
  end

  always_comb begin
    state_d = state_q;
    if (hs) begin
      case (state_q)
        TRX_IDLE:      state_d = TRX_STREAMING;
        TRX_STREAMING: state_d = is_wfi_last ? TRX_ENDED : TRX_STREAMING;
        TRX_ENDED:     state_d = TRX_STREAMING;
        default:       state_d = TRX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRX_IDLE;
    end else if (clear) begin
      state_q <= TRX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_acc         <= '0;
      pkt_count      <= '0;
      frame_count    <= '0;
      err_zero_delta <= 1'b0;
    end else if (clear) begin
      ts_acc         <= '0;
      pkt_count      <= '0;
      frame_count    <= '0;
      err_zero_delta <= 1'b0;
    end else if (hs) begin
      ts_acc <= out_timestamp;
      if (pkt_count != 32'hFFFF_FFFF) pkt_count <= pkt_count + 32'd1;
      if (out_last) frame_count <= frame_count + 32'd1;
      if (out_clk_delta == '0) err_zero_delta <= 1'b1;
    end
  end

`ifdef TRACE_RX_EVENT_TOTALS_EN
  logic [TOTAL_WIDTH-1:0] total_q [NO_OF_PERFORMANCE_EVENTS];
  logic [TOTAL_WIDTH-1:0] total_d [NO_OF_PERFORMANCE_EVENTS];
  logic [TOTAL_WIDTH:0]   inc     [NO_OF_PERFORMANCE_EVENTS];
  logic [TOTAL_WIDTH:0]   sum     [NO_OF_PERFORMANCE_EVENTS];

  // overflow bit is the carry out of the modulo counter, so it lands just above it
  always_comb begin
    for (int i = 0; i < NO_OF_PERFORMANCE_EVENTS; i++) begin
      inc[i]          = '0;
      inc[i][CW:0]    = {head.overflow_map[i], event_counter(head, i)};
      sum[i]          = {1'b0, total_q[i]} + inc[i];
      total_d[i]      = sum[i][TOTAL_WIDTH] ? '1 : sum[i][TOTAL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NO_OF_PERFORMANCE_EVENTS; i++) total_q[i] <= '0;
      total_value <= '0;
    end else if (clear) begin
      for (int i = 0; i < NO_OF_PERFORMANCE_EVENTS; i++) total_q[i] <= '0;
      total_value <= '0;
    end else begin
      if (hs) begin
        for (int i = 0; i < NO_OF_PERFORMANCE_EVENTS; i++) total_q[i] <= total_d[i];
      end
      total_value <= total_q[total_sel];
    end
  end
`endif

endmodule

// File: tb/tb_trace_stream_receiver.sv
// Randomized bench for trace_stream_receiver with a queue-based packet/timestamp reference model.
module tb_trace_stream_receiver;
  import continuous_monitoring_system_pkg::*;

  localparam int NE = NO_OF_PERFORMANCE_EVENTS;
  localparam int CW = PERFORMANCE_EVENT_MOD_COUNTER_WIDTH;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                                rst_n;
  logic                                S_AXIS_tvalid;
  logic                                S_AXIS_tready;
  logic [AXI_DATA_WIDTH-1:0]           S_AXIS_tdata;
  logic                                S_AXIS_tlast;
  logic                                clear;
  logic                                out_valid;
  logic                                out_ready;
  logic [RISC_V_INSTRUCTION_WIDTH-1:0] out_instr;
  logic [XLEN-1:0]                     out_pc;
  logic [CLK_COUNTER_WIDTH-1:0]        out_clk_delta;
  logic [63:0]                         out_timestamp;
  logic [NE-1:0]                       out_overflow_map;
  logic [NE*CW-1:0]                    out_counters;
  logic                                out_last;
  logic [31:0]                         pkt_count;
  logic [31:0]                         frame_count;
  logic                                end_of_trace;
  logic                                err_zero_delta;
`ifdef TRACE_RX_EVENT_TOTALS_EN
  logic [$clog2(NE)-1:0]               total_sel;
  logic [47:0]                         total_value;
`endif

  trace_stream_receiver dut (
    .clk(clk), .rst_n(rst_n),
    .S_AXIS_tvalid(S_AXIS_tvalid), .S_AXIS_tready(S_AXIS_tready),
    .S_AXIS_tdata(S_AXIS_tdata), .S_AXIS_tlast(S_AXIS_tlast),
    .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc), .out_clk_delta(out_clk_delta),
    .out_timestamp(out_timestamp), .out_overflow_map(out_overflow_map),
    .out_counters(out_counters), .out_last(out_last),
    .pkt_count(pkt_count), .frame_count(frame_count),
    .end_of_trace(end_of_trace), .err_zero_delta(err_zero_delta)
`ifdef TRACE_RX_EVENT_TOTALS_EN
    , .total_sel(total_sel), .total_value(total_value)
`endif
  );

  typedef struct packed {
    logic [31:0]                  instr;
    logic [CLK_COUNTER_WIDTH-1:0] delta;
    logic [XLEN-1:0]              pc;
    logic [NE-1:0]                ovf;
    logic [NE-1:0][CW-1:0]        cnt;
    logic                         last;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  beat_t       tx_q[$];
  beat_t       exp_q[$];
  logic [63:0] obs_ts[$];
  beat_t       cur_beat;
  logic [63:0] m_ts;
  int          m_state;   // 0 idle, 1 streaming, 2 ended
  logic [31:0] m_pkt, m_frame;
  logic        m_err, m_blocked;
  logic        saw_tready_low;

  // Counter region built with event 0 shifted up to the MSB end
  function automatic logic [AXI_DATA_WIDTH-1:0] to_tdata(input beat_t b);
    logic [NE*CW-1:0] r;
    r = '0;
    for (int i = 0; i < NE; i++) r = {r[NE*CW-CW-1:0], b.cnt[i]};
    return {b.instr, b.delta, b.pc, b.ovf, r};
  endfunction

  function automatic beat_t mk_beat(input int delta, input logic wfi, input logic last);
    beat_t b;
    b.instr = $urandom;
    if (b.instr == WFI_INSTRUCTION) b.instr = b.instr ^ 32'h1;
    if (wfi) b.instr = WFI_INSTRUCTION;
    b.delta = delta[CLK_COUNTER_WIDTH-1:0];
    b.pc    = $urandom;
    b.ovf   = NE'($urandom);
    for (int i = 0; i < NE; i++) b.cnt[i] = CW'($urandom);
    b.last  = last;
    return b;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_ts = '0; m_state = 0; m_pkt = '0; m_frame = '0; m_err = 1'b0;
  endfunction

  // Called just after a negedge with inputs set; covers the following posedge.
  task automatic step();
    beat_t       b;
    logic [63:0] ets;
    #1;
    if (!rst_n) begin model_reset(); m_blocked = 1'b1; end
    checks++; if (S_AXIS_tready !== (!m_blocked && exp_q.size() < 2)) begin errors++; $display("FAIL tready got %b want %b", S_AXIS_tready, !m_blocked && exp_q.size() < 2); end
    checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL out_valid got %b want %b", out_valid, exp_q.size() != 0); end
    checks++; if (pkt_count !== m_pkt) begin errors++; $display("FAIL pkt_count got %0d want %0d", pkt_count, m_pkt); end
    checks++; if (frame_count !== m_frame) begin errors++; $display("FAIL frame_count got %0d want %0d", frame_count, m_frame); end
    checks++; if (end_of_trace !== (m_state == 2)) begin errors++; $display("FAIL end_of_trace got %b want %b", end_of_trace, m_state == 2); end
    checks++; if (err_zero_delta !== m_err) begin errors++; $display("FAIL err_zero_delta got %b want %b", err_zero_delta, m_err); end
    if (rst_n && out_valid && out_ready && exp_q.size() > 0) begin
      b   = exp_q.pop_front();
      ets = ((m_state == 2) ? 64'd0 : m_ts) + 64'(b.delta);
      checks++; if (out_instr !== b.instr) begin errors++; $display("FAIL instr got %h want %h", out_instr, b.instr); end
      checks++; if (out_pc !== b.pc) begin errors++; $display("FAIL pc got %h want %h", out_pc, b.pc); end
      checks++; if (out_clk_delta !== b.delta) begin errors++; $display("FAIL delta got %0d want %0d", out_clk_delta, b.delta); end
      checks++; if (out_timestamp !== ets) begin errors++; $display("FAIL timestamp got %0d want %0d", out_timestamp, ets); end
      checks++; if (out_overflow_map !== b.ovf) begin errors++; $display("FAIL overflow_map got %h want %h", out_overflow_map, b.ovf); end
      checks++; if (out_counters !== b.cnt) begin errors++; $display("FAIL counters got %h want %h", out_counters, b.cnt); end
      checks++; if (out_last !== b.last) begin errors++; $display("FAIL last got %b want %b", out_last, b.last); end
      obs_ts.push_back(out_timestamp);
      m_ts = ets;
      if (m_pkt != 32'hFFFF_FFFF) m_pkt++;
      if (b.last) m_frame++;
      if (b.delta == 0) m_err = 1'b1;
      if (m_state == 1 && b.last && b.instr == WFI_INSTRUCTION) m_state = 2;
      else m_state = 1;
    end
    if (rst_n && S_AXIS_tvalid && S_AXIS_tready && !clear) exp_q.push_back(cur_beat);
    if (!S_AXIS_tready) saw_tready_low = 1'b1;
    if (clear) model_reset();
    m_blocked = !rst_n || clear;
    @(negedge clk);
  endtask

  task automatic run(input int max_cycles, input logic [31:0] rdy_mask);
    int   c;
    logic acc;
    c = 0;
    while ((tx_q.size() > 0 || exp_q.size() > 0) && c < max_cycles) begin
      if (tx_q.size() > 0) begin
        cur_beat = tx_q[0];
        S_AXIS_tvalid = 1'b1; S_AXIS_tdata = to_tdata(cur_beat); S_AXIS_tlast = cur_beat.last;
      end else begin
        S_AXIS_tvalid = 1'b0;
      end
      out_ready = (c < 32) ? rdy_mask[c] : 1'b1;
      acc = S_AXIS_tvalid && S_AXIS_tready;
      step();
      if (acc) void'(tx_q.pop_front());
      c++;
    end
    S_AXIS_tvalid = 1'b0;
    checks++;
    if (tx_q.size() != 0 || exp_q.size() != 0) begin
      errors++; $display("FAIL run_timeout left tx %0d out %0d want 0 0", tx_q.size(), exp_q.size());
      tx_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; S_AXIS_tvalid = 1'b0; S_AXIS_tdata = '0; S_AXIS_tlast = 1'b0;
    clear = 1'b0; out_ready = 1'b0; m_blocked = 1'b1; model_reset();
`ifdef TRACE_RX_EVENT_TOTALS_EN
    total_sel = '0;
`endif
    @(negedge clk);
    step(); step();
    checks++; if (out_timestamp !== 64'd0) begin errors++; $display("FAIL reset_timestamp got %0d want 0", out_timestamp); end
    checks++; if (out_counters !== '0) begin errors++; $display("FAIL reset_counters got %h want 0", out_counters); end
    rst_n = 1'b1;
    step(); step();
    checks++; if (S_AXIS_tready !== 1'b1) begin errors++; $display("FAIL release_tready got %b want 1", S_AXIS_tready); end
  endtask

  task automatic test_basic();
    obs_ts.delete();
    tx_q.push_back(mk_beat(5, 0, 0));
    tx_q.push_back(mk_beat(7, 0, 0));
    tx_q.push_back(mk_beat(1, 0, 0));
    run(50, 32'hFFFF_FFFF);
    checks++; if (obs_ts.size() != 3) begin errors++; $display("FAIL basic_count got %0d want 3", obs_ts.size()); end
    else begin
      checks++; if (obs_ts[0] !== 64'd5)  begin errors++; $display("FAIL basic_ts0 got %0d want 5", obs_ts[0]); end
      checks++; if (obs_ts[1] !== 64'd12) begin errors++; $display("FAIL basic_ts1 got %0d want 12", obs_ts[1]); end
      checks++; if (obs_ts[2] !== 64'd13) begin errors++; $display("FAIL basic_ts2 got %0d want 13", obs_ts[2]); end
    end
    checks++; if (pkt_count !== 32'd3) begin errors++; $display("FAIL basic_pkt_count got %0d want 3", pkt_count); end
  endtask

  task automatic test_back_to_back();
    saw_tready_low = 1'b0;
    obs_ts.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back(mk_beat(i + 2, 0, 0));
    run(60, ~32'h1C);
    checks++; if (saw_tready_low !== 1'b1) begin errors++; $display("FAIL b2b_tready_drop got %b want 1", saw_tready_low); end
    checks++; if (obs_ts.size() != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", obs_ts.size()); end
  endtask

  task automatic test_end_of_trace();
    tx_q.push_back(mk_beat($urandom_range(1, 100), 1, 1));
    run(50, 32'hFFFF_FFFF);
    checks++; if (end_of_trace !== 1'b1) begin errors++; $display("FAIL eot_set got %b want 1", end_of_trace); end
    checks++; if (frame_count !== 32'd1) begin errors++; $display("FAIL eot_frame got %0d want 1", frame_count); end
    obs_ts.delete();
    tx_q.push_back(mk_beat(9, 0, 0));
    run(50, 32'hFFFF_FFFF);
    checks++; if (obs_ts.size() != 1 || obs_ts[0] !== 64'd9) begin errors++; $display("FAIL eot_restart_ts got %0d want 9", (obs_ts.size() > 0) ? obs_ts[0] : 64'd0); end
    checks++; if (end_of_trace !== 1'b0) begin errors++; $display("FAIL eot_clear got %b want 0", end_of_trace); end
  endtask

  task automatic test_zero_delta_clear();
    tx_q.push_back(mk_beat(0, 0, 0));
    for (int i = 0; i < 10; i++) tx_q.push_back(mk_beat($urandom_range(1, 50), 0, $urandom_range(0, 1)));
    run(200, $urandom);
    checks++; if (err_zero_delta !== 1'b1) begin errors++; $display("FAIL zero_delta_sticky got %b want 1", err_zero_delta); end
    // beat offered during clear must be lost
    cur_beat = mk_beat(3, 0, 1);
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = to_tdata(cur_beat); S_AXIS_tlast = 1'b1;
    clear = 1'b1; out_ready = 1'b1;
    step();
    clear = 1'b0; S_AXIS_tvalid = 1'b0;
    checks++; if (S_AXIS_tready !== 1'b0) begin errors++; $display("FAIL clear_tready got %b want 0", S_AXIS_tready); end
    checks++; if (pkt_count !== 32'd0 || frame_count !== 32'd0) begin errors++; $display("FAIL clear_counts got %0d/%0d want 0/0", pkt_count, frame_count); end
    checks++; if (err_zero_delta !== 1'b0) begin errors++; $display("FAIL clear_err got %b want 0", err_zero_delta); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_lost_beat got %b want 0", out_valid); end
    step();
    checks++; if (S_AXIS_tready !== 1'b1) begin errors++; $display("FAIL clear_tready_back got %b want 1", S_AXIS_tready); end
  endtask

  task automatic test_reset_midstream();
    cur_beat = mk_beat(4, 0, 0);
    S_AXIS_tvalid = 1'b1; S_AXIS_tdata = to_tdata(cur_beat); S_AXIS_tlast = 1'b0; out_ready = 1'b0;
    step();
    S_AXIS_tvalid = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    checks++; if (out_instr !== '0 || out_pc !== '0 || out_clk_delta !== '0) begin errors++; $display("FAIL rst_fields got %h/%h/%h want 0", out_instr, out_pc, out_clk_delta); end
    checks++; if (out_timestamp !== 64'd0 || out_last !== 1'b0 || out_overflow_map !== '0) begin errors++; $display("FAIL rst_misc got %0d/%b/%h want 0", out_timestamp, out_last, out_overflow_map); end
    rst_n = 1'b1; out_ready = 1'b1;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_stale got %b want 0", out_valid); end
    for (int i = 0; i < 5; i++) tx_q.push_back(mk_beat($urandom_range(1, 30), 0, 0));
    run(100, 32'hFFFF_FFFF);
  endtask

  task automatic test_random();
    for (int blk = 0; blk < 15; blk++) begin
      for (int i = 0; i < 10; i++) begin
        logic lst;
        lst = ($urandom_range(0, 3) == 0);
        tx_q.push_back(mk_beat(($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 65535),
                               lst && ($urandom_range(0, 2) == 0), lst));
      end
      run(400, $urandom);
    end
  endtask

`ifdef TRACE_RX_EVENT_TOTALS_EN
  task automatic test_totals();
    beat_t b;
    logic [47:0] exp_total;
    clear = 1'b1; step(); clear = 1'b0; step();
    total_sel = 2'd3;
    b = mk_beat(1, 0, 0); b.cnt[3] = 8'd10; b.ovf[3] = 1'b1; tx_q.push_back(b);
    b = mk_beat(1, 0, 0); b.cnt[3] = 8'd5;  b.ovf[3] = 1'b0; tx_q.push_back(b);
    run(50, 32'hFFFF_FFFF);
    step(); step();
    exp_total = (48'd1 << CW) + 48'd15;
    checks++; if (total_value !== exp_total) begin errors++; $display("FAIL total_ev3 got %0d want %0d", total_value, exp_total); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_end_of_trace();
    test_zero_delta_clear();
    test_reset_midstream();
    test_random();
`ifdef TRACE_RX_EVENT_TOTALS_EN
    test_totals();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
